// File: rtl/cache_pkg.sv
// Shared types and bus message encoding for the MSI cache controller.
package cache_pkg;

    localparam int NUM_LINES = 2;
    localparam int CMD_W     = 2;
    localparam int TAG_W     = 2;
    localparam int VAL_W     = 4;
    localparam int MSG_W     = CMD_W + TAG_W + VAL_W;

    // Bus commands carried in msg[7:6]
    localparam logic [CMD_W-1:0] IDLE = 2'b00;
    localparam logic [CMD_W-1:0] RM   = 2'b01;
    localparam logic [CMD_W-1:0] WM   = 2'b10;
    localparam logic [CMD_W-1:0] WB   = 2'b11;

    typedef enum logic [1:0] {I = 2'b00, S = 2'b01, M = 2'b10} line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_FLUSH, ST_WBACK, ST_RMISS, ST_RFILL, ST_WMISS, ST_RESP
    } fsm_state_t;

    typedef struct packed {
        line_state_t      st;
        logic             tag;
        logic [VAL_W-1:0] data;
    } line_t;

    function automatic logic [MSG_W-1:0] mk_msg(input logic [CMD_W-1:0] cmd,
                                                input logic [TAG_W-1:0] tag,
                                                input logic [VAL_W-1:0] val);
        return {cmd, tag, val};
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Processor request/response and snooping-bus signals of one cache controller.
interface cache_controller_if;
    import cache_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [TAG_W-1:0] req_addr;
    logic [VAL_W-1:0] req_data;
    logic             resp_valid;
    logic [VAL_W-1:0] resp_data;
    logic             bus_req;
    logic             bus_grant;
    logic [MSG_W-1:0] bus_out;
    logic [MSG_W-1:0] bus_in;
    logic             bus_in_valid;
    logic [VAL_W-1:0] mem_q;

    modport master (
        input  req_valid, req_write, req_addr, req_data,
        input  bus_grant, bus_in, bus_in_valid, mem_q,
        output req_ready, resp_valid, resp_data, bus_req, bus_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data,
        output bus_grant, bus_in, bus_in_valid, mem_q,
        input  req_ready, resp_valid, resp_data, bus_req, bus_out
    );

endinterface

// File: rtl/cache_line_array.sv
// Two direct-mapped lines: processor and snoop read ports, one write port, and the
// snoop state update applied on top of any same-cycle write to that line.
module cache_line_array
    import cache_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             rd_idx,
    output line_t            rd_line,
    input  logic             sn_valid,
    input  logic [CMD_W-1:0] sn_cmd,
    input  logic             sn_idx,
    input  logic             sn_tag,
    output line_t            sn_line,
    input  logic             wr_en,
    input  logic             wr_idx,
    input  line_t            wr_line
);

    line_t [NUM_LINES-1:0] lines;
    line_t [NUM_LINES-1:0] merged;
    line_t [NUM_LINES-1:0] nxt;

    // A snoop landing in the fill cycle is ordered after our own fill on the bus,
    // so it must act on the freshly written line.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            merged[k] = (wr_en && wr_idx == 1'(k)) ? wr_line : lines[k];
            nxt[k]    = merged[k];
            if (sn_valid && sn_idx == 1'(k) && merged[k].st != I && merged[k].tag == sn_tag) begin
                if (sn_cmd == WM)
                    nxt[k].st = I;
                else if (sn_cmd == RM && merged[k].st == M)
                    nxt[k].st = S;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            lines <= '0;
        else
            lines <= nxt;
    end

    assign rd_line = lines[rd_idx];
    assign sn_line = merged[sn_idx];

endmodule

// File: rtl/cache_controller.sv
// Per-processor MSI cache controller on the shared 8-bit snooping bus.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller
    import cache_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    cache_controller_if.master cif
`ifdef CACHE_STATS_EN
    ,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
`endif
);

    fsm_state_t       state;
    logic             wr_q;
    logic [TAG_W-1:0] addr_q;
    logic [VAL_W-1:0] data_q;
    logic             flush_pending;
    logic [TAG_W-1:0] flush_tag;
    logic [VAL_W-1:0] flush_data;
    logic             resp_valid_q;
    logic [VAL_W-1:0] resp_data_q;
    logic             bus_req_q;
    logic [MSG_W-1:0] bus_out_q;

    line_t rd_line, sn_line, wr_line;
    logic  wr_en;
    logic  idx, hit, granted, decide, snoop_flush;

    assign idx     = addr_q[0];
    assign hit     = rd_line.st != I && rd_line.tag == addr_q[1];
    assign granted = bus_req_q && cif.bus_grant;
    // A snoop in LOOKUP takes the cycle; the decision is retried on the updated line.
    assign decide  = state == ST_LOOKUP && !cif.bus_in_valid;
    assign snoop_flush = cif.bus_in_valid && cif.bus_in[7:6] == RM &&
                         sn_line.st == M && sn_line.tag == cif.bus_in[5];

    cache_line_array u_lines (
        .clock    (clock),
        .resetn   (resetn),
        .rd_idx   (idx),
        .rd_line  (rd_line),
        .sn_valid (cif.bus_in_valid),
        .sn_cmd   (cif.bus_in[7:6]),
        .sn_idx   (cif.bus_in[4]),
        .sn_tag   (cif.bus_in[5]),
        .sn_line  (sn_line),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_line  (wr_line)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_line = rd_line;
        case (state)
            ST_LOOKUP: if (decide && hit && wr_q && rd_line.st == M) begin
                wr_en        = 1'b1;
                wr_line.data = data_q;
            end
            ST_WBACK: if (granted) begin
                wr_en      = 1'b1;
                wr_line.st = I;
            end
            ST_RFILL: begin
                wr_en   = 1'b1;
                wr_line = '{st: S, tag: addr_q[1], data: cif.mem_q};
            end
            ST_WMISS: if (granted) begin
                wr_en   = 1'b1;
                wr_line = '{st: M, tag: addr_q[1], data: data_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            flush_pending <= 1'b0;
            flush_tag     <= '0;
            flush_data    <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            bus_req_q     <= 1'b0;
            bus_out_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_pending) begin
                        state     <= ST_FLUSH;
                        bus_req_q <= 1'b1;
                        bus_out_q <= mk_msg(WB, flush_tag, flush_data);
                    end else if (cif.req_valid) begin
                        state  <= ST_LOOKUP;
                        wr_q   <= cif.req_write;
                        addr_q <= cif.req_addr;
                        data_q <= cif.req_data;
                    end
                end
                ST_LOOKUP: if (decide) begin
                    if (hit && (!wr_q || rd_line.st == M)) begin
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= wr_q ? data_q : rd_line.data;
                    end else if (!hit && rd_line.st == M) begin
                        state     <= ST_WBACK;
                        bus_req_q <= 1'b1;
                        bus_out_q <= mk_msg(WB, {rd_line.tag, idx}, rd_line.data);
                    end else if (wr_q) begin
                        state     <= ST_WMISS;
                        bus_req_q <= 1'b1;
                        bus_out_q <= mk_msg(WM, addr_q, data_q);
                    end else begin
                        state     <= ST_RMISS;
                        bus_req_q <= 1'b1;
                        bus_out_q <= mk_msg(RM, addr_q, '0);
                    end
                end
                ST_WBACK: if (granted) begin
                    state     <= wr_q ? ST_WMISS : ST_RMISS;
                    bus_out_q <= wr_q ? mk_msg(WM, addr_q, data_q) : mk_msg(RM, addr_q, '0);
                end
                ST_RMISS: if (granted) begin
                    state     <= ST_RFILL;
                    bus_req_q <= 1'b0;
                    bus_out_q <= '0;
                end
                ST_RFILL: begin
                    state        <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= cif.mem_q;
                end
                ST_WMISS: if (granted) begin
                    state        <= ST_RESP;
                    bus_req_q    <= 1'b0;
                    bus_out_q    <= '0;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= data_q;
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
                ST_FLUSH: if (granted) begin
                    state         <= ST_IDLE;
                    flush_pending <= 1'b0;
                    bus_req_q     <= 1'b0;
                    bus_out_q     <= '0;
                end
                default: state <= ST_IDLE;
            endcase
            // Owner's grant cycle never carries a snoop, so this cannot race the flush clear.
            if (snoop_flush) begin
                flush_pending <= 1'b1;
                flush_tag     <= cif.bus_in[5:4];
                flush_data    <= sn_line.data;
            end
        end
    end

    assign cif.req_ready  = state == ST_IDLE && !flush_pending;
    assign cif.resp_valid = resp_valid_q;
    assign cif.resp_data  = resp_data_q;
    assign cif.bus_req    = bus_req_q;
    assign cif.bus_out    = bus_out_q;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (decide) begin
            if (hit && hit_count != 8'hFF)
                hit_count <= hit_count + 8'd1;
            else if (!hit && miss_count != 8'hFF)
                miss_count <= miss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: bus messages, responses, snoops and reset.
module tb_cache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    cache_controller_if cif();

`ifdef CACHE_STATS_EN
    logic [7:0] hit_count, miss_count;
`endif

    cache_controller dut (
        .clock  (clk),
        .resetn (resetn),
        .cif    (cif)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] msgs[$];
    logic       rsp_seen;
    logic [3:0] rsp_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m(input int i);
        return (i < msgs.size()) ? 32'(msgs[i]) : 32'hDEAD;
    endfunction

    // Runs one request to completion, granting the bus after gwait idle cycles
    // and logging each committed message.
    task automatic xact(input logic w, input logic [1:0] a, input logic [3:0] d,
                        input logic [3:0] mv, input int gwait);
        int   waited = 0;
        logic acc;
        msgs.delete();
        rsp_seen = 1'b0;
        rsp_data = '0;
        cif.req_write = w;
        cif.req_addr  = a;
        cif.req_data  = d;
        cif.mem_q     = mv;
        cif.req_valid = 1'b1;
        for (int c = 0; c < 60 && !rsp_seen; c++) begin
            acc = cif.req_valid && cif.req_ready;
            cif.bus_grant = 1'b0;
            if (cif.bus_req) begin
                if (waited >= gwait) begin
                    cif.bus_grant = 1'b1;
                    msgs.push_back(cif.bus_out);
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            @(negedge clk);
            if (acc) cif.req_valid = 1'b0;
            if (cif.resp_valid) begin
                rsp_seen = 1'b1;
                rsp_data = cif.resp_data;
            end
        end
        cif.bus_grant = 1'b0;
        cif.req_valid = 1'b0;
        chk("resp_seen", 32'(rsp_seen), 1);
        @(negedge clk);
    endtask

    task automatic snoop(input logic [7:0] msg);
        cif.bus_in       = msg;
        cif.bus_in_valid = 1'b1;
        @(negedge clk);
        cif.bus_in_valid = 1'b0;
        cif.bus_in       = '0;
    endtask

    initial begin
        resetn           = 1'b0;
        cif.req_valid    = 1'b0;
        cif.req_write    = 1'b0;
        cif.req_addr     = '0;
        cif.req_data     = '0;
        cif.bus_grant    = 1'b0;
        cif.bus_in       = '0;
        cif.bus_in_valid = 1'b0;
        cif.mem_q        = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cif.req_ready), 1);
        chk("rst_resp_valid", 32'(cif.resp_valid), 0);
        chk("rst_bus_req", 32'(cif.bus_req), 0);
        chk("rst_bus_out", 32'(cif.bus_out), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Cold read fills line 0 in S
        xact(1'b0, 2'b10, 4'h0, 4'hA, 0);
        chk("cold_nmsg", msgs.size(), 1);
        chk("cold_rm", m(0), 8'h60);
        chk("cold_data", 32'(rsp_data), 4'hA);
        chk("resp_pulse", 32'(cif.resp_valid), 0);
        xact(1'b0, 2'b10, 4'h0, 4'hF, 0);
        chk("s_hit_nmsg", msgs.size(), 0);
        chk("s_hit_data", 32'(rsp_data), 4'hA);

        // Write to an S line upgrades via WM
        xact(1'b1, 2'b10, 4'h5, 4'hF, 0);
        chk("upg_nmsg", msgs.size(), 1);
        chk("upg_wm", m(0), 8'hA5);
        chk("upg_data", 32'(rsp_data), 4'h5);
        xact(1'b0, 2'b10, 4'h0, 4'hF, 0);
        chk("m_hit_nmsg", msgs.size(), 0);
        chk("m_hit_data", 32'(rsp_data), 4'h5);

        // Conflict miss on a dirty line: write-back before the read miss
        xact(1'b0, 2'b00, 4'h0, 4'hC, 0);
        chk("evict_nmsg", msgs.size(), 2);
        chk("evict_wb", m(0), 8'hE5);
        chk("evict_rm", m(1), 8'h40);
        chk("evict_data", 32'(rsp_data), 4'hC);
        xact(1'b0, 2'b10, 4'h0, 4'h5, 0);
        chk("clean_evict_nmsg", msgs.size(), 1);
        chk("clean_evict_rm", m(0), 8'h60);
        chk("clean_evict_data", 32'(rsp_data), 4'h5);

        // Snooped RM on a dirty line forces a flush before the pending request
        xact(1'b1, 2'b11, 4'h7, 4'hF, 0);
        chk("wmiss_nmsg", msgs.size(), 1);
        chk("wmiss_wm", m(0), 8'hB7);
        snoop(8'h70);
        chk("flush_block_ready", 32'(cif.req_ready), 0);
        xact(1'b0, 2'b11, 4'h0, 4'hF, 0);
        chk("flush_nmsg", msgs.size(), 1);
        chk("flush_wb", m(0), 8'hF7);
        chk("flush_then_hit", 32'(rsp_data), 4'h7);

        // Snooped WM invalidates a matching S line only
        xact(1'b0, 2'b01, 4'h0, 4'h9, 0);
        chk("rm1_nmsg", msgs.size(), 1);
        chk("rm1_rm", m(0), 8'h50);
        chk("rm1_data", 32'(rsp_data), 4'h9);
        snoop(8'hB0);
        xact(1'b0, 2'b01, 4'h0, 4'hF, 0);
        chk("snoop_miss_nmsg", msgs.size(), 0);
        chk("snoop_miss_data", 32'(rsp_data), 4'h9);
        snoop(8'h9C);
        xact(1'b0, 2'b01, 4'h0, 4'h3, 0);
        chk("inval_nmsg", msgs.size(), 1);
        chk("inval_rm", m(0), 8'h50);
        chk("inval_data", 32'(rsp_data), 4'h3);

        // Ungranted RM is held, then reset abandons it
        cif.req_write = 1'b0;
        cif.req_addr  = 2'b00;
        cif.mem_q     = 4'h1;
        cif.req_valid = 1'b1;
        @(negedge clk);
        cif.req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 32'(cif.bus_req), 1);
            chk("hold_msg", 32'(cif.bus_out), 8'h40);
            @(negedge clk);
        end
        #2 resetn = 1'b0;
        #1;
        chk("arst_ready", 32'(cif.req_ready), 1);
        chk("arst_resp_valid", 32'(cif.resp_valid), 0);
        chk("arst_bus_req", 32'(cif.bus_req), 0);
        chk("arst_bus_out", 32'(cif.bus_out), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(cif.resp_valid), 0);
        end

        // Lines come back invalid after reset
        xact(1'b0, 2'b01, 4'h0, 4'h4, 0);
        chk("post_rst1_nmsg", msgs.size(), 1);
        chk("post_rst1_rm", m(0), 8'h50);
        chk("post_rst1_data", 32'(rsp_data), 4'h4);
        xact(1'b0, 2'b10, 4'h0, 4'h8, 0);
        chk("post_rst0_rm", m(0), 8'h60);
        chk("post_rst0_data", 32'(rsp_data), 4'h8);

        // Write miss on clean conflict, then write hit on M stays off the bus
        xact(1'b1, 2'b00, 4'h2, 4'hF, 2);
        chk("wm_nmsg", msgs.size(), 1);
        chk("wm_msg", m(0), 8'h82);
        chk("wm_data", 32'(rsp_data), 4'h2);
        xact(1'b1, 2'b00, 4'h6, 4'hF, 0);
        chk("whit_nmsg", msgs.size(), 0);
        chk("whit_data", 32'(rsp_data), 4'h6);
        snoop(8'h40);
        xact(1'b0, 2'b00, 4'h0, 4'hF, 0);
        chk("flush2_nmsg", msgs.size(), 1);
        chk("flush2_wb", m(0), 8'hC6);
        chk("flush2_data", 32'(rsp_data), 4'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Per-processor MSI cache controller; the upstream stage that drives the shared 8-bit snooping bus consumed by the 4x4 memory.
- Holds 2 direct-mapped one-word lines and serves processor reads and writes.
- Issues RM / WM / WB bus messages, snoops other agents' messages, and captures memory read data.
- Bus message format: [7:6] cmd, [5:4] tag (block address), [3:0] value.

Parameters:
- IDLE, 2'b00, bus cmd "no operation".
- RM, 2'b01, read-miss cmd; memory answers on mem_q.
- WM, 2'b10, write-miss/invalidate cmd; memory ignores it.
- WB, 2'b11, write-back cmd; memory stores value at tag.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  processor request valid.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2  block address; [0] = line index, [1] = stored tag bit.
- req_data  in  4  write data.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_data  out  4  read data, valid with resp_valid.
- bus_req  out  1  request bus ownership.
- bus_grant  in  1  arbiter grant; a message is committed on a cycle with bus_req && bus_grant.
- bus_out  out  8  message driven when granted; 8'h00 otherwise.
- bus_in  in  8  snooped bus contents from other agents.
- bus_in_valid  in  1  bus_in holds another agent's committed message.
- mem_q  in  4  memory read data.

Behaviour:
- Reset (async, resetn=0): all lines I, data 0; FSM IDLE; req_ready=1; resp_valid=0; bus_req=0; bus_out=8'h00; flush_pending=0.
- FSM states: IDLE, LOOKUP, FLUSH, WBACK, RMISS, RFILL, WMISS, RESP.
- IDLE: req_ready=1. On req_valid, latch req_write/req_addr/req_data and go to LOOKUP. If flush_pending=1, go to FLUSH first and hold req_ready=0.
- LOOKUP (req_ready=0):
  - Read hit (S or M): RESP.
  - Write hit, line M: update data, RESP.
  - Write hit, line S: WMISS.
  - Miss with victim in M: WBACK.
  - Miss otherwise: RMISS if read, WMISS if write.
- WBACK: bus_req=1, bus_out={WB, victim_tag, victim_data}. On grant, victim line goes to I; then RMISS or WMISS.
- RMISS: bus_req=1, bus_out={RM, tag, 4'h0}. On grant, go to RFILL.
- RFILL: capture mem_q on this cycle (one cycle after grant); line becomes S with that data; go to RESP.
- WMISS: bus_req=1, bus_out={WM, tag, req_data}. On grant, line becomes M with req_data; go to RESP. Whole-word write, so no fetch is needed.
- RESP: resp_valid=1 for one cycle; resp_data = line data (read) or written data (write); return to IDLE.
- FLUSH: bus_req=1, bus_out={WB, flush_tag, flush_data}. On grant, clear flush_pending and return to IDLE.
- Snoop (bus_in_valid=1, any state, compared against the line at bus_in[4] with stored tag bus_in[5]):
  - RM hitting M: line goes to S, set flush_pending, record flush_tag/flush_data.
  - WM hitting S or M: line goes to I.
  - WB, or any miss: no effect.
- Snoop priority: a snoop and LOOKUP in the same cycle apply the snoop first; LOOKUP stays one extra cycle and re-evaluates the updated line.
- Bus holding: bus_req and bus_out stay stable until granted; any wait length is legal.
- Own messages: the controller never snoops its own committed message. The arbiter deasserts bus_in_valid on the owner's cycle.
- Reset asserted mid-transaction: the transaction is abandoned, all state is cleared, and no response is produced.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined, add outputs hit_count [7:0] and miss_count [7:0]. Each increments once per completed LOOKUP decision, saturates at 8'hFF, and resets to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - bus cmd constants IDLE/RM/WM/WB;
  - typedef line_state_t {I, S, M};
  - typedef fsm_state_t;
  - message field widths.
- One natural sub-module: cache_line_array. It holds 2 entries {state, tag bit, data}, provides a combinational read port for the processor index and one for the snoop index, and one write port with a snoop update path.

Test Plan:
- Cold read at addr 2'b10, grant immediate, mem_q=4'hA → bus_out=8'h6_0 (RM, tag 2), then resp_data=4'hA; line 0 in S.
- Write 4'h5 at addr 2'b10 (line S) → bus_out=8'hA5 (WM, tag 2, data 5); line M; resp_valid pulse.
- Line 0 M (tag 2, data 4'h5), then read addr 2'b00 → bus_out=8'hE5 (WB) then 8'h40 (RM); victim written back before the fill.
- Line M at addr 3 holding 4'h7, snoop bus_in=8'h70 valid → line goes to S; next bus message is 8'hF7 (WB), even with a request pending.
- Line S at addr 1, snoop 8'h9C (WM, tag 1) → line I; following read of addr 1 issues RM.
- bus_grant low for 5 cycles during RMISS → bus_out held at 8'h40; reset pulse mid-wait → all outputs return to reset values.
